// File: rtl/int_tx_ascii_pkg.sv
// Shared definitions for the integer-to-ASCII TX front end: FSM encodings,
// ASCII constants and digit-count helpers.
package int_tx_pkg;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_CARGA     = 3'd1,
      S_CONVERTIR = 3'd2,
      S_SIGNO     = 3'd3,
      S_DIGITOS   = 3'd4,
      S_TERM_CR   = 3'd5,
      S_TERM_LF   = 3'd6
   } state_t;

   localparam logic [7:0] ASCII_0     = 8'h30;
   localparam logic [7:0] ASCII_A_OFS = 8'h37;
   localparam logic [7:0] ASCII_MINUS = 8'h2D;
   localparam logic [7:0] ASCII_CR    = 8'h0D;
   localparam logic [7:0] ASCII_LF    = 8'h0A;

   // log10(2) ~= 0.302, rounded up to whole digits
   function automatic int dec_digits(input int nbit);
      return (nbit * 302 + 999) / 1000;
   endfunction

   function automatic int hex_digits(input int nbit);
      return (nbit + 3) / 4;
   endfunction

endpackage

// File: rtl/int_tx_ascii_bin2bcd_seq.sv
// Iterative double-dabble: start_i loads the value, done_o flags the edge
// on which the final (NBIT-th) add-3/shift step is applied.
module bin2bcd_seq
   import int_tx_pkg::*;
#(
   parameter int NBIT = 8,
   parameter int NDIG = dec_digits(NBIT)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start_i,
   input  logic [NBIT-1:0]     bin_i,
   output logic                done_o,
   output logic [4*NDIG-1:0]   bcd_o
);

   localparam int SW = 4 * NDIG + NBIT;
   localparam int CW = $clog2(NBIT + 1);

   logic [SW-1:0] sh_q;
   logic [SW-1:0] adj;
   logic [CW-1:0] cnt_q;
   logic          busy_q;

   generate
      for (genvar gi = 0; gi < NDIG; gi++) begin : g_adj
         logic [3:0] nib;
         assign nib = sh_q[NBIT + 4*gi +: 4];
         assign adj[NBIT + 4*gi +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
      end
   endgenerate
   assign adj[NBIT-1:0] = sh_q[NBIT-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_q   <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
      end else if (start_i) begin
         sh_q   <= {{(4*NDIG){1'b0}}, bin_i};
         cnt_q  <= CW'(NBIT);
         busy_q <= 1'b1;
      end else if (busy_q) begin
         sh_q  <= adj << 1;
         cnt_q <= cnt_q - CW'(1);
         if (cnt_q == CW'(1)) busy_q <= 1'b0;
      end
   end

   assign done_o = busy_q && (cnt_q == CW'(1));
   assign bcd_o  = sh_q[SW-1 -: 4*NDIG];

endmodule

// File: rtl/int_tx_ascii.sv
// Prints an NBIT ALU result as decimal (optionally signed) or hex ASCII into
// the UART TX FIFO. Define INT_TX_TERM_EN to append CR/LF to every string.
module int_tx_ascii
   import int_tx_pkg::*;
#(
   parameter int NBIT = 8
) (
   input  logic            CLK,
   input  logic            RESET_N,
   input  logic            ENVIAR,
   input  logic [NBIT-1:0] DATO_ALU,
   input  logic            MODO_HEX,
   input  logic            CON_SIGNO,
   input  logic            FIFO_FULL,
   output logic            WR_FIFO,
   output logic [7:0]      DATA_FIFO,
   output logic            BUSY,
   output logic            DONE,
   output logic [2:0]      STATE
);

   localparam int DEC_DIGITS = dec_digits(NBIT);
   localparam int HEX_DIGITS = hex_digits(NBIT);
   localparam int MAX_DIG    = (DEC_DIGITS > HEX_DIGITS) ? DEC_DIGITS : HEX_DIGITS;
   localparam int IDX_W      = $clog2(MAX_DIG + 1);

   state_t            state_q;
   logic [NBIT-1:0]   dato_q;
   logic              hex_q;
   logic              signo_q;
   logic              neg_q;
   logic              lead_q;
   logic [IDX_W-1:0]  idx_q;
   logic              done_q;

   logic              neg_d;
   logic [NBIT-1:0]   mag_d;
   logic              bcd_done;
   logic [4*DEC_DIGITS-1:0] bcd;
   logic [4*MAX_DIG-1:0]    dec_pad, hex_pad, dig_vec;
   logic [3:0]        digit;
   logic [7:0]        asc;
   logic              skip;
   logic              wr;
   logic [7:0]        ch;

   // Magnitude is NBIT-bit unsigned so the most negative value maps to 2^(NBIT-1)
   assign neg_d = signo_q & ~hex_q & dato_q[NBIT-1];
   assign mag_d = neg_d ? -dato_q : dato_q;

   bin2bcd_seq #(.NBIT(NBIT), .NDIG(DEC_DIGITS)) u_bcd (
      .clk     (CLK),
      .rst_n   (RESET_N),
      .start_i (state_q == S_CARGA && !hex_q),
      .bin_i   (mag_d),
      .done_o  (bcd_done),
      .bcd_o   (bcd)
   );

   assign dec_pad = (4*MAX_DIG)'(bcd);
   assign hex_pad = (4*MAX_DIG)'(dato_q);
   assign dig_vec = hex_q ? hex_pad : dec_pad;
   assign digit   = dig_vec[4*idx_q +: 4];
   assign asc     = (digit < 4'd10) ? ASCII_0 + {4'd0, digit} : ASCII_A_OFS + {4'd0, digit};
   assign skip    = lead_q && (digit == 4'd0) && (idx_q != '0);

   always_comb begin
      wr = 1'b0;
      ch = 8'h00;
      case (state_q)
         S_SIGNO:   begin wr = !FIFO_FULL;          ch = ASCII_MINUS; end
         S_DIGITOS: begin wr = !skip && !FIFO_FULL; ch = asc;         end
`ifdef INT_TX_TERM_EN
         S_TERM_CR: begin wr = !FIFO_FULL;          ch = ASCII_CR;    end
         S_TERM_LF: begin wr = !FIFO_FULL;          ch = ASCII_LF;    end
`endif
         default: ;
      endcase
   end

   assign WR_FIFO   = wr;
   assign DATA_FIFO = wr ? ch : 8'h00;
   assign BUSY      = (state_q != S_IDLE);
   assign DONE      = done_q;
   assign STATE     = state_q;

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q <= S_IDLE;
         dato_q  <= '0;
         hex_q   <= 1'b0;
         signo_q <= 1'b0;
         neg_q   <= 1'b0;
         lead_q  <= 1'b0;
         idx_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: if (ENVIAR) begin
               dato_q  <= DATO_ALU;
               hex_q   <= MODO_HEX;
               signo_q <= CON_SIGNO;
               state_q <= S_CARGA;
            end
            S_CARGA: begin
               neg_q   <= neg_d;
               lead_q  <= 1'b1;
               idx_q   <= hex_q ? IDX_W'(HEX_DIGITS - 1) : IDX_W'(DEC_DIGITS - 1);
               state_q <= hex_q ? S_DIGITOS : S_CONVERTIR;
            end
            S_CONVERTIR: if (bcd_done) state_q <= neg_q ? S_SIGNO : S_DIGITOS;
            S_SIGNO: if (wr) state_q <= S_DIGITOS;
            S_DIGITOS: begin
               if (skip) begin
                  idx_q <= idx_q - IDX_W'(1);
               end else if (wr) begin
                  lead_q <= 1'b0;
                  if (idx_q == '0) begin
`ifdef INT_TX_TERM_EN
                     state_q <= S_TERM_CR;
`else
                     state_q <= S_IDLE;
                     done_q  <= 1'b1;
`endif
                  end else begin
                     idx_q <= idx_q - IDX_W'(1);
                  end
               end
            end
`ifdef INT_TX_TERM_EN
            S_TERM_CR: if (wr) state_q <= S_TERM_LF;
            S_TERM_LF: if (wr) begin
               state_q <= S_IDLE;
               done_q  <= 1'b1;
            end
`endif
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule
